// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch sequencer. Issues one instruction-memory read at a time,
// captures the response into the fetch register (instr_f / pc_f / valid_f),
// holds it until downstream consumes it, and then advances the pc by 4.
// A redirect replaces the pc at any time. Any response belonging to a request
// made before the redirect is dropped. A response that arrives after reset
// release without a matching request is also dropped.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   stall           downstream not ready, the held instruction stays put
//   redirect_valid  redirect the fetch stream to redirect_pc
//   redirect_pc     new fetch address
//   imem_rdata      read data, valid with imem_resp
//   imem_resp       one-cycle pulse, the read response is present
//   imem_addr       read address (always the current pc)
//   imem_rmask      4'b1111 while a request is issued, else 4'b0000
//   instr_f         fetched instruction
//   pc_f            address of instr_f
//   valid_f         instr_f / pc_f hold a valid instruction
//   fetch_count     instructions consumed since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic        valid_f,
    output logic [31:0] fetch_count
);

    // REQ     : request issued this cycle
    // WAIT    : request outstanding, its data will be kept
    // HOLD    : instruction held in the fetch register
    // DISCARD : request outstanding, its data will be dropped
    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc_f_d;
    logic        valid_d;
    logic [31:0] count_d;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr_f     <= '0;
            pc_f        <= '0;
            valid_f     <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr_f     <= instr_d;
            pc_f        <= pc_f_d;
            valid_f     <= valid_d;
            fetch_count <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so paths that do
        // not assign it cannot infer a latch.
        state_d = state;
        pc_d    = pc;
        instr_d = instr_f;
        pc_f_d  = pc_f;
        valid_d = valid_f;
        count_d = fetch_count;

        case (state)
            S_REQ: begin
                // The request goes out at the old pc regardless. A redirect
                // here makes its response stale.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_resp) begin
                    if (redirect_valid) begin
                        // The response arrives together with the redirect: drop it.
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else begin
                        instr_d = imem_rdata;
                        pc_f_d  = pc;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_DISCARD;
                end
            end

            S_HOLD: begin
                // A redirect wins over stall and is not counted as a consumption.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = pc + 32'd4;
                    valid_d = 1'b0;
                    count_d = fetch_count + 32'd1;
                    state_d = S_REQ;
                end
            end

            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    state_d = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    // Output logic. rmask is gated by rst because the request must not be
    // visible while reset holds the state in REQ.
    always_comb begin
        imem_addr  = pc;
        imem_rmask = (rst && state == S_REQ) ? 4'b1111 : 4'b0000;
    end

endmodule
